multiplier_top: RTL and testbench

Iterative signed/unsigned integer multiplier with a valid/ready-style handshake and a synchronous flush. It accepts two XLEN-bit operands and returns the full 2·XLEN-bit product, split into high and low halves, after a fixed multi-cycle latency. It sits beside the integer pipeline as a long-latency execution unit. The pipeline can abort an in-flight operation with `flush`.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/multiplier_if.sv | 25 ++
 rtl/multiplier_booth_sel.sv | 33 +++
 rtl/multiplier_top.sv | 103 ++++++++++
 tb/tb_multiplier_top.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// Imported by the Booth selector and the multiplier top level.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_e;

  // One radix-4 digit per cycle over the (XLEN+2)-bit extended multiplier.
  function automatic int unsigned mul_iters(input int unsigned xlen);
    return (xlen + 2) / 2;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_e booth_decode(input logic [2:0] win);
    booth_e sel;
    unique case (win)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multiplier_if.sv
// Request/response bundle between the integer pipeline (master) and the
// multiplier (slave).
interface mul_if #(
  parameter int XLEN = 32
);
  logic            inready;
  logic            invalid;
  logic            flush;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            outvalid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    input  inready, outvalid, result_hi, result_lo,
    output invalid, flush, mul_signed, multiplicand, multiplier
  );

  modport slave (
    output inready, outvalid, result_hi, result_lo,
    input  invalid, flush, mul_signed, multiplicand, multiplier
  );
endinterface

// File: rtl/multiplier_booth_sel.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier window to
// 0, +-A or +-2A, sign-extended two bits beyond the extended multiplicand.
module booth_sel
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      win,
  input  logic [XLEN+1:0] a_ext,
  output logic [XLEN+3:0] pp
);

  booth_e          sel;
  logic [XLEN+3:0] a_wide;
  logic [XLEN+3:0] a_dbl;

  assign sel    = booth_decode(win);
  assign a_wide = {{2{a_ext[XLEN+1]}}, a_ext};
  assign a_dbl  = {a_wide[XLEN+2:0], 1'b0};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pp = '0;
    unique case (sel)
      POS1:    pp = a_wide;
      POS2:    pp = a_dbl;
      NEG1:    pp = '0 - a_wide;
      NEG2:    pp = '0 - a_dbl;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/multiplier_top.sv
// Iterative signed/unsigned XLEN x XLEN multiplier, radix-4 Booth, one digit
// per cycle, with valid/ready handshake and synchronous flush.
module multiplier_top
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  mul_if.slave bus
);

  localparam int W     = XLEN + 2;
  localparam int ITERS = mul_iters(XLEN);
  localparam int CW    = $clog2(ITERS);

  state_e          state, state_nxt;
  logic [W-1:0]    a_q;
  logic [2*W-1:0]  p_q, p_nxt;
  logic            prev_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] res_hi_q, res_lo_q;

  logic            accept, last;
  logic [W-1:0]    a_ext_in, b_ext_in;
  logic [W+1:0]    pp, hi_sum;

  assign accept = (state == IDLE) && bus.invalid && !bus.flush;
  assign last   = (cnt_q == CW'(ITERS - 1));

  assign a_ext_in = {{2{bus.mul_signed[1] & bus.multiplicand[XLEN-1]}}, bus.multiplicand};
  assign b_ext_in = {{2{bus.mul_signed[0] & bus.multiplier[XLEN-1]}},   bus.multiplier};

  booth_sel #(.XLEN(XLEN)) u_booth_sel (
    .win   ({p_q[1:0], prev_q}),
    .a_ext (a_q),
    .pp    (pp)
  );

  // Upper half accumulates, lower half holds the unconsumed multiplier; each
  // step adds the partial product and shifts the whole register right by two.
  assign hi_sum = {{2{p_q[2*W-1]}}, p_q[2*W-1:W]} + pp;
  assign p_nxt  = {hi_sum, p_q[W-1:2]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.invalid) state_nxt = BUSY;
        BUSY:    if (last)        state_nxt = DONE;
        DONE:                     state_nxt = IDLE;
        default:                  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.inready  = (state == IDLE);
    bus.outvalid = (state == DONE) && !bus.flush;
  end

  // NOTE: the datapath is a handful of flops, not a memory, so all of it is
  // cleared on reset and nothing leaks from an aborted operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      p_q      <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      if (accept) begin
        a_q    <= a_ext_in;
        p_q    <= {{W{1'b0}}, b_ext_in};
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else if (state == BUSY) begin
        p_q    <= p_nxt;
        prev_q <= p_q[1];
        cnt_q  <= cnt_q + 1'b1;
      end
      // Results change only on entry to DONE and hold until the next one.
      if (state == BUSY && last && !bus.flush) begin
        res_hi_q <= p_nxt[2*XLEN-1:XLEN];
        res_lo_q <= p_nxt[XLEN-1:0];
      end
    end
  end

  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;

endmodule

// File: tb/tb_multiplier_top.sv
// Directed self-checking bench for multiplier_top (XLEN=32): products,
// latency, flush, mid-operation reset and handshake corner cases.
module tb_multiplier_top;

  localparam int XLEN  = 32;
  localparam int ITERS = (XLEN + 2) / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  mul_if #(.XLEN(XLEN)) bus ();

  multiplier_top #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic watch(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.outvalid) pulses++;
      @(negedge clk);
    end
  endtask

  // Issue one operation from a negedge, then check latency, result and hold.
  task automatic run_op(input string tag, input logic [1:0] ms,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    check({tag, " inready"}, 64'(bus.inready), 64'd1);
    bus.invalid      = 1'b1;
    bus.mul_signed   = ms;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge clk);
    bus.invalid      = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.mul_signed   = 2'($urandom);
    lat = 0;
    while (!bus.outvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(ITERS));
    check({tag, " hi"}, 64'(bus.result_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.result_lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " single pulse"}, 64'(bus.outvalid), 64'd0);
    check({tag, " ready after done"}, 64'(bus.inready), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, " hold"}, {bus.result_hi, bus.result_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int pulses;
    int accepts;

    bus.invalid      = 1'b0;
    bus.flush        = 1'b0;
    bus.mul_signed   = 2'b00;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    #1;
    check("reset inready",  64'(bus.inready),  64'd1);
    check("reset outvalid", 64'(bus.outvalid), 64'd0);
    check("reset result",   {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("ss small",  2'b11, 32'h0000_0010, 32'h0000_0004, 32'h0000_0000, 32'h0000_0040);
    run_op("ss neg",    2'b11, 32'h8000_0010, 32'h8000_0004, 32'h3FFF_FFF6, 32'h0000_0040);
    run_op("su neg",    2'b10, 32'h8000_0010, 32'h8000_0004, 32'hC000_0006, 32'h0000_0040);
    run_op("uu big",    2'b00, 32'h8000_0010, 32'h8000_0004, 32'h4000_000A, 32'h0000_0040);
    run_op("us neg",    2'b01, 32'h8000_0010, 32'h8000_0004, 32'hBFFF_FFFA, 32'h0000_0040);
    run_op("uu max",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("ss m1",     2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("su m1",     2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Flush five cycles into an operation.
    bus.invalid      = 1'b1;
    bus.mul_signed   = 2'b11;
    bus.multiplicand = 32'h0000_1234;
    bus.multiplier   = 32'h0000_0010;
    @(negedge clk);
    bus.invalid = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush ready", 64'(bus.inready), 64'd1);
    watch(25, pulses);
    check("flush no outvalid", 64'(pulses), 64'd0);
    check("flush keeps result", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_0000_0001);
    run_op("post flush", 2'b10, 32'h8000_0010, 32'h8000_0004, 32'hC000_0006, 32'h0000_0040);

    // Asynchronous reset in the middle of BUSY.
    bus.invalid      = 1'b1;
    bus.mul_signed   = 2'b00;
    bus.multiplicand = 32'h0000_0003;
    bus.multiplier   = 32'h0000_0007;
    @(negedge clk);
    bus.invalid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset inready",  64'(bus.inready),  64'd1);
    check("midreset outvalid", 64'(bus.outvalid), 64'd0);
    check("midreset result",   {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch(25, pulses);
    check("midreset no outvalid", 64'(pulses), 64'd0);

    // Request held high across a whole operation and into the next.
    bus.invalid      = 1'b1;
    bus.mul_signed   = 2'b00;
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd5;
    accepts = 0;
    pulses  = 0;
    for (int j = 0; j < 20; j++) begin
      if (bus.inready) accepts++;
      if (bus.outvalid) pulses++;
      @(negedge clk);
    end
    bus.invalid = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (bus.outvalid) pulses++;
      @(negedge clk);
    end
    check("held accepts", 64'(accepts), 64'd2);
    check("held pulses",  64'(pulses),  64'd2);
    check("held result",  {bus.result_hi, bus.result_lo}, 64'd15);

    // Flush and request together in IDLE: nothing is accepted.
    bus.flush   = 1'b1;
    bus.invalid = 1'b1;
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.invalid = 1'b0;
    check("flush+invalid ready", 64'(bus.inready), 64'd1);
    watch(25, pulses);
    check("flush+invalid no outvalid", 64'(pulses), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
